example_result_capture: RTL and testbench

- Downstream stage of the `example` DUT. Samples the DUT result `z` whenever the DUT qualifies it valid, and buffers the samples in a FIFO.
- Presents the buffered samples on a valid/ready port to the co-emulation transactor or monitor, so the host can drain results at its own rate.
- Keeps a running sample count, a checksum and a sticky overflow flag, so result loss is detectable without reading every sample.

---
 rtl/example_result_capture.sv | 145 ++++++++++++++
 tb/tb_example_result_capture.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/example_result_capture.sv
// Result capture stage: samples qualified DUT results into a first-word fall-through FIFO and
// keeps sample count, checksum and drop statistics. Optional macro: RESULT_CAPTURE_TIMESTAMP_EN.
module example_result_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          z_in,
    input  logic                       z_valid,
`ifdef RESULT_CAPTURE_TIMESTAMP_EN
    output logic [CNT_W+DATA_W-1:0]    out_data,
`else
    output logic [DATA_W-1:0]          out_data,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           count,
    output logic [CNT_W-1:0]           checksum,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
`ifdef RESULT_CAPTURE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = CNT_W + DATA_W;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0] head_q, head_d, wdata;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d, sum_q, sum_d, drop_q, drop_d;
    logic               ovf_q, ovf_d;
    logic               full, pop, push, drop;

`ifdef RESULT_CAPTURE_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else if (clear) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + CNT_W'(1);
        end
    end

    assign wdata = {ts_q, z_in};
`else
    assign wdata = z_in;
`endif

    always_comb begin
        full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop  = valid_q && out_ready;
        push = z_valid && (!full || pop);
        drop = z_valid && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sum_d    = sum_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        head_d   = head_q;
        valid_d  = valid_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sum_d    = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                count_d  = count_q + CNT_W'(1);
                sum_d    = sum_q + CNT_W'(z_in);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
            // Bypass the write when the new head is the slot being written this edge.
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = wdata;
            end else begin
                head_d = mem[rd_ptr_d[AW-1:0]];
            end
            valid_d = (wr_ptr_d != rd_ptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_data   = head_q;
    assign out_valid  = valid_q;
    assign count      = count_q;
    assign checksum   = sum_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
    assign level      = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_example_result_capture.sv
// Scoreboard bench for example_result_capture: a reference occupancy/counter model decides
// acceptance, expected samples queue on push and are compared when the DUT pops them.
module tb_example_result_capture;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 16;
`ifdef RESULT_CAPTURE_TIMESTAMP_EN
    localparam int unsigned OUT_W = CNT_W + DATA_W;
`else
    localparam int unsigned OUT_W = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] z_in = '0;
    logic              z_valid = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  count, checksum, drop_count;
    logic              overflow;
    logic [$clog2(DEPTH):0] level;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] sb[$];
    int                m_level = 0;
    logic [CNT_W-1:0]  m_count = '0, m_sum = '0, m_drop = '0;
    logic              m_ovf = 1'b0;
    logic [DATA_W-1:0] last_pop = '0;

    example_result_capture #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .z_in      (z_in),
        .z_valid   (z_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .checksum  (checksum),
        .drop_count(drop_count),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sb.delete();
        m_level = 0;
        m_count = '0;
        m_sum   = '0;
        m_drop  = '0;
        m_ovf   = 1'b0;
    endtask

    // One clock: check/pop the scoreboard for the current inputs, advance the model, step the DUT.
    task automatic tick();
        bit pop, push;
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] got;
        pop = (m_level != 0) && out_ready;
        checks++;
        if (out_valid !== (m_level != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_level != 0);
        end
        if (pop) begin
            exp = sb.pop_front();
            got = out_data[DATA_W-1:0];
            last_pop = got;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pop_data: got %h expected %h", got, exp);
            end
        end
        push = z_valid && !clear && (m_level < DEPTH || pop);
        if (clear) begin
            model_reset();
        end else begin
            if (push) begin
                sb.push_back(z_in);
                m_count = m_count + 1'b1;
                m_sum   = m_sum + CNT_W'(z_in);
            end else if (z_valid) begin
                m_ovf = 1'b1;
                if (m_drop != '1) m_drop = m_drop + 1'b1;
            end
            m_level = m_level + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
        checks++;
        if (int'(level) != m_level) begin
            errors++;
            $display("FAIL level: got %0d expected %0d", level, m_level);
        end
    endtask

    task automatic drain(input int max_cycles);
        z_valid   = 1'b0;
        z_in      = 'x;
        out_ready = 1'b1;
        for (int i = 0; i < max_cycles && m_level != 0; i++) tick();
        checks++;
        if (m_level != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: out_valid %b model level %0d expected empty", out_valid, m_level);
        end
    endtask

    task automatic do_clear();
        clear   = 1'b1;
        z_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || count !== '0 || checksum !== '0 ||
            drop_count !== '0 || overflow !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset: v=%b lvl=%0d cnt=%h sum=%h drop=%h ovf=%b data=%h expected all 0",
                     out_valid, level, count, checksum, drop_count, overflow, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] vals [3];
        vals[0] = 8'h05; vals[1] = 8'h0A; vals[2] = 8'h0F;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            z_valid = 1'b1;
            z_in    = vals[i];
            tick();
        end
        drain(10);
        checks++;
        if (count !== 16'd3 || checksum !== 16'h001E || level !== '0) begin
            errors++;
            $display("FAIL basic: cnt=%h sum=%h lvl=%0d expected 0003 001e 0", count, checksum, level);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        z_valid   = 1'b1;
        z_in      = 8'h11;
        tick();
        z_valid = 1'b0;
        z_in    = 'x;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[DATA_W-1:0] !== 8'h11 || level !== 5'd1) begin
                errors++;
                $display("FAIL backpressure: v=%b data=%h lvl=%0d expected 1 11 1",
                         out_valid, out_data[DATA_W-1:0], level);
            end
            tick();
        end
        drain(5);
    endtask

    task automatic test_overflow();
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            z_valid = 1'b1;
            z_in    = DATA_W'(i);
            tick();
        end
        z_valid = 1'b0;
        checks++;
        if (level !== 5'd16 || drop_count !== 16'd4 || overflow !== 1'b1 ||
            count !== 16'd16 || checksum !== 16'h0078) begin
            errors++;
            $display("FAIL overflow: lvl=%0d drop=%0d ovf=%b cnt=%0d sum=%h expected 16 4 1 16 0078",
                     level, drop_count, overflow, count, checksum);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1;
        z_valid   = 1'b1;
        z_in      = 8'hAA;
        tick();
        checks++;
        if (level !== 5'd16 || drop_count !== 16'd4 || count !== 16'd17) begin
            errors++;
            $display("FAIL full_pop: lvl=%0d drop=%0d cnt=%0d expected 16 4 17",
                     level, drop_count, count);
        end
        drain(20);
        checks++;
        if (last_pop !== 8'hAA) begin
            errors++;
            $display("FAIL full_pop_last: got %h expected aa", last_pop);
        end
    endtask

    task automatic test_clear();
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            z_valid = 1'b1;
            z_in    = DATA_W'(8'h40 + i);
            tick();
        end
        z_valid   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        out_ready = 1'b0;
        checks++;
        if (level !== 5'd5 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup: lvl=%0d ovf=%b expected 5 1", level, overflow);
        end
        clear   = 1'b1;
        z_valid = 1'b1;
        z_in    = 8'h77;
        tick();
        clear   = 1'b0;
        z_valid = 1'b0;
        checks++;
        if (level !== '0 || count !== '0 || checksum !== '0 || drop_count !== '0 ||
            overflow !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear: lvl=%0d cnt=%h sum=%h drop=%h ovf=%b v=%b expected all 0",
                     level, count, checksum, drop_count, overflow, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            z_valid = 1'b1;
            z_in    = DATA_W'(8'h90 + i);
            tick();
        end
        z_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || count !== '0 || checksum !== '0 ||
            drop_count !== '0 || overflow !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: v=%b lvl=%0d cnt=%h sum=%h data=%h expected all 0",
                     out_valid, level, count, checksum, out_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        z_valid = 1'b1;
        z_in    = 8'h3C;
        tick();
        z_valid = 1'b0;
        checks++;
        if (count !== 16'd1 || checksum !== 16'h003C || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: cnt=%0d sum=%h v=%b expected 1 003c 1",
                     count, checksum, out_valid);
        end
        drain(5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
